// File: rtl/mem_block_mover.sv
// mem_block_mover
// Command sequencer for a byte-wide memory with a registered read port.
// It takes one block command at a time and produces the memory address,
// write data and read/write strobes. The commands are FILL (write a constant),
// COPY (read a byte, then write it) and SUM (add bytes modulo 2**DATA_W).
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        asynchronous reset, active low
//   i_start        command strobe, only honoured while idle
//   i_op           00 FILL, 01 COPY, 10 SUM, 11 reserved (runs as length 0)
//   i_src_addr     COPY/SUM start address
//   i_dst_addr     FILL/COPY start address
//   i_length       byte count, 0..2**ADDR_W
//   i_fill_value   byte written by FILL
//   o_busy         high while a command is in progress
//   o_done         one-cycle completion pulse
//   o_result       last SUM result, held until the next SUM completes
//   o_mem_address  memory address
//   o_mem_data_in  memory write data
//   o_mem_read_en  memory read strobe
//   o_mem_write_en memory write strobe
//   i_mem_data_out memory read data, valid the cycle after o_mem_read_en
module mem_block_mover #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [ADDR_W:0]   i_length,
    input  logic [DATA_W-1:0] i_fill_value,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data_in,
    output logic              o_mem_read_en,
    output logic              o_mem_write_en,
    input  logic [DATA_W-1:0] i_mem_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_CAP,
        S_WR,
        S_FIN
    } state_t;

    localparam logic [1:0]      OP_FILL = 2'b00;
    localparam logic [1:0]      OP_COPY = 2'b01;
    localparam logic [1:0]      OP_SUM  = 2'b10;
    localparam logic [1:0]      OP_RSVD = 2'b11;
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state, w_state_next;
    logic [1:0]          r_op, w_op_next;
    logic [ADDR_W-1:0]   r_src, w_src_next;
    logic [ADDR_W-1:0]   r_dst, w_dst_next;
    logic [ADDR_W:0]     r_len, w_len_next;
    logic [DATA_W-1:0]   r_fill, w_fill_next;
    logic [ADDR_W:0]     r_idx, w_idx_next;
    logic [DATA_W-1:0]   r_acc, w_acc_next;
    logic                r_fin_hold, w_fin_hold_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic [DATA_W-1:0]   r_result, w_result_next;
    logic [ADDR_W-1:0]   r_mem_address, w_mem_address_next;
    logic [DATA_W-1:0]   r_mem_data_in, w_mem_data_in_next;
    logic                r_mem_read_en, w_mem_read_en_next;
    logic                r_mem_write_en, w_mem_write_en_next;

    logic [ADDR_W:0]     w_idx_inc;
    logic [ADDR_W:0]     w_cmd_len;

    assign w_idx_inc = r_idx + IDX_ONE;
    // The reserved opcode behaves exactly like a zero-length command.
    assign w_cmd_len = (i_op == OP_RSVD) ? '0 : i_length;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_op           <= '0;
            r_src          <= '0;
            r_dst          <= '0;
            r_len          <= '0;
            r_fill         <= '0;
            r_idx          <= '0;
            r_acc          <= '0;
            r_fin_hold     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_mem_address  <= '0;
            r_mem_data_in  <= '0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_op           <= w_op_next;
            r_src          <= w_src_next;
            r_dst          <= w_dst_next;
            r_len          <= w_len_next;
            r_fill         <= w_fill_next;
            r_idx          <= w_idx_next;
            r_acc          <= w_acc_next;
            r_fin_hold     <= w_fin_hold_next;
            r_busy         <= w_busy_next;
            r_done         <= w_done_next;
            r_result       <= w_result_next;
            r_mem_address  <= w_mem_address_next;
            r_mem_data_in  <= w_mem_data_in_next;
            r_mem_read_en  <= w_mem_read_en_next;
            r_mem_write_en <= w_mem_write_en_next;
        end
    end

    // Every output is a register loaded with the value it must carry in the
    // state being entered, so the strobes line up with the state they belong to.
    always_comb begin
        w_state_next        = r_state;
        w_op_next           = r_op;
        w_src_next          = r_src;
        w_dst_next          = r_dst;
        w_len_next          = r_len;
        w_fill_next         = r_fill;
        w_idx_next          = r_idx;
        w_acc_next          = r_acc;
        w_fin_hold_next     = r_fin_hold;
        w_busy_next         = r_busy;
        w_done_next         = 1'b0;
        w_result_next       = r_result;
        w_mem_address_next  = r_mem_address;
        w_mem_data_in_next  = r_mem_data_in;
        w_mem_read_en_next  = 1'b0;
        w_mem_write_en_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                // r_done is still high in the cycle after FIN; a start seen then is dropped.
                if (i_start && !r_done) begin
                    w_op_next   = i_op;
                    w_src_next  = i_src_addr;
                    w_dst_next  = i_dst_addr;
                    w_len_next  = w_cmd_len;
                    w_fill_next = i_fill_value;
                    w_idx_next  = '0;
                    w_acc_next  = '0;
                    w_busy_next = 1'b1;
                    if (w_cmd_len == '0) begin
                        // An empty command waits one extra cycle in FIN, so its done
                        // pulse comes two cycles after start.
                        w_state_next    = S_FIN;
                        w_fin_hold_next = 1'b1;
                    end else if (i_op == OP_FILL) begin
                        w_state_next        = S_WR;
                        w_mem_write_en_next = 1'b1;
                        w_mem_address_next  = i_dst_addr;
                        w_mem_data_in_next  = i_fill_value;
                    end else begin
                        w_state_next       = S_RD_ISSUE;
                        w_mem_read_en_next = 1'b1;
                        w_mem_address_next = i_src_addr;
                    end
                end
            end

            S_RD_ISSUE: begin
                w_state_next = S_RD_CAP;
            end

            S_RD_CAP: begin
                if (r_op == OP_COPY) begin
                    // The byte read for COPY goes straight into the write-data register.
                    w_state_next        = S_WR;
                    w_mem_write_en_next = 1'b1;
                    w_mem_address_next  = r_dst + r_idx[ADDR_W-1:0];
                    w_mem_data_in_next  = i_mem_data_out;
                end else begin
                    w_acc_next = r_acc + i_mem_data_out;
                    w_idx_next = w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_state_next       = S_RD_ISSUE;
                        w_mem_read_en_next = 1'b1;
                        w_mem_address_next = r_src + w_idx_inc[ADDR_W-1:0];
                    end
                end
            end

            S_WR: begin
                w_idx_next = w_idx_inc;
                if (w_idx_inc == r_len) begin
                    w_state_next = S_FIN;
                end else if (r_op == OP_FILL) begin
                    w_mem_write_en_next = 1'b1;
                    w_mem_address_next  = r_dst + w_idx_inc[ADDR_W-1:0];
                    w_mem_data_in_next  = r_fill;
                end else begin
                    w_state_next       = S_RD_ISSUE;
                    w_mem_read_en_next = 1'b1;
                    w_mem_address_next = r_src + w_idx_inc[ADDR_W-1:0];
                end
            end

            S_FIN: begin
                if (r_fin_hold) begin
                    w_fin_hold_next = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    // An empty SUM leaves the previous result in place.
                    if (r_op == OP_SUM && r_len != '0) begin
                        w_result_next = r_acc;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_result       = r_result;
    assign o_mem_address  = r_mem_address;
    assign o_mem_data_in  = r_mem_data_in;
    assign o_mem_read_en  = r_mem_read_en;
    assign o_mem_write_en = r_mem_write_en;

endmodule
